// File: rtl/carrier_band_mixer.sv
`default_nettype none
// ============================================================================
// Module   : carrier_band_mixer
// Brief    : Snapshots carrier bands and envelope gains on each sample tick,
//            sums the weighted bands with one sequential MAC, then rounds,
//            scales and saturates to a signed 16-bit vocoder output sample.
// Revision : 1.0 - initial release
// ============================================================================
module carrier_band_mixer #(
    parameter int NUM_BANDS = 15,
    parameter int OUT_SHIFT = 4,
    parameter int ACC_WIDTH = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_tick,
    input  logic [NUM_BANDS-1:0][15:0]  carrier_bands,
    input  logic [NUM_BANDS-1:0]        valid_bus,
    input  logic [NUM_BANDS-1:0][15:0]  envelopes,
    input  logic [NUM_BANDS-1:0]        band_enable,
    input  logic                        clear_overrun,
    output logic signed [15:0]          mix_out,
    output logic                        mix_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int C_FRAC = 16 + OUT_SHIFT;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_BANDS - 1);

    localparam logic signed [ACC_WIDTH:0] C_ROUND_BIAS =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (C_FRAC - 1);
    localparam logic signed [ACC_WIDTH:0] C_SAT_MAX =
        {{(ACC_WIDTH-15){1'b0}}, 16'h7FFF};
    localparam logic signed [ACC_WIDTH:0] C_SAT_MIN =
        {{(ACC_WIDTH-15){1'b1}}, 16'h8000};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_capture;
    logic                    w_mac_en;
    logic                    w_done;

    logic signed [15:0]      r_band [NUM_BANDS];
    logic        [15:0]      r_env  [NUM_BANDS];
    logic [NUM_BANDS-1:0]    r_valid_mask;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [IDX_W-1:0]        r_idx;

    logic signed [15:0]      w_band_sel;
    logic        [15:0]      w_env_sel;
    logic                    w_term_valid;
    logic signed [32:0]      w_product;
    logic signed [ACC_WIDTH-1:0] w_term;
    logic signed [ACC_WIDTH:0]   w_rounded;
    logic signed [ACC_WIDTH:0]   w_shifted;
    logic signed [15:0]      w_sat;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_mac_en    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sample_tick) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                w_mac_en = 1'b1;
                if (r_idx == C_LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (r_state != ST_IDLE);

    // ------------------------------------------------------------------------
    // Input snapshot; only written on an accepted tick
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_snap
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_band[gi] <= '0;
                    r_env[gi]  <= '0;
                end else if (w_capture) begin
                    r_band[gi] <= carrier_bands[gi];
                    r_env[gi]  <= envelopes[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_mask <= '0;
        end else if (w_capture) begin
            r_valid_mask <= valid_bus & band_enable;
        end
    end

    // ------------------------------------------------------------------------
    // Multiply-accumulate datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_band_sel   = r_band[r_idx];
        w_env_sel    = r_env[r_idx];
        w_term_valid = r_valid_mask[r_idx];
        // Gain is unsigned Q0.16, so widen with a zero sign bit before multiply
        w_product    = 33'(w_band_sel) * 33'($signed({1'b0, w_env_sel}));
        w_term       = w_term_valid ? ACC_WIDTH'(w_product) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_capture) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_mac_en) begin
            r_acc <= r_acc + w_term;
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Round half up, scale, saturate
    // ------------------------------------------------------------------------
    always_comb begin
        w_rounded = $signed({r_acc[ACC_WIDTH-1], r_acc}) + C_ROUND_BIAS;
        w_shifted = w_rounded >>> C_FRAC;
        if (w_shifted > C_SAT_MAX) begin
            w_sat = 16'sh7FFF;
        end else if (w_shifted < C_SAT_MIN) begin
            w_sat = -16'sh8000;
        end else begin
            w_sat = w_shifted[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mix_out   <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= w_done;
            if (w_done) begin
                mix_out <= w_sat;
            end
        end
    end

    // A dropped tick must win over a simultaneous clear so it is never lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (sample_tick && (r_state != ST_IDLE)) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/carrier_band_mixer.md
# carrier_band_mixer

Sink-side partner of the carrier ROM bank. It snapshots the 15 carrier band samples and their per-band valid bits on every 44.1 kHz sample tick, and weights each band by an envelope gain from the modulator analysis path. It sums the products with one time-multiplexed multiplier-accumulator, then rounds, scales and saturates the result to one signed 16-bit vocoder output sample with a single-cycle valid pulse.

## Interface
- `NUM_BANDS`, 15, number of carrier bands. The FSM index and port widths derive from it.
- `OUT_SHIFT`, 4, extra right shift applied after the Q0.16 gain shift. This is the master attenuation.
- `ACC_WIDTH`, 36, signed accumulator width. It is sized for 15 × (−32768 × 65535) without overflow.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `sample_tick`  in  1  one-cycle strobe at 44.1 kHz, meaning "bands are stable, capture now"
- `carrier_bands`  in  [NUM_BANDS] × signed 16  carrier band samples
- `valid_bus`  in  NUM_BANDS  per-band valid bits
- `envelopes`  in  [NUM_BANDS] × unsigned 16  per-band gain, Q0.16 (65535 ≈ 1.0)
- `band_enable`  in  NUM_BANDS  static per-band mute mask (1 = band used)
- `clear_overrun`  in  1  clears the sticky overrun flag
- `mix_out`  out  signed 16  mixed output sample, held until the next result
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates
- `busy`  out  1  high while a mix is in progress
- `overrun`  out  1  sticky flag: a tick arrived while busy

## Operation
- **States:** IDLE, MAC, DONE.
- **IDLE:**
  - On `sample_tick`, register all 15 bands and all 15 envelopes into snapshot registers.
  - Register the effective valid mask, `valid_bus & band_enable`.
  - Clear the accumulator, set index to 0, then go to MAC.
- **MAC:** each cycle adds `band[idx] × {1'b0, env[idx]}` (33-bit signed product) to the accumulator.
  - The add happens only if the effective valid bit for `idx` is set. Otherwise the term is 0.
  - `idx` increments each cycle. After `idx == NUM_BANDS−1` is accumulated, go to DONE.
- **DONE:**
  - Compute `r = (acc + 2^(15+OUT_SHIFT)) >>> (16+OUT_SHIFT)`, an arithmetic shift that rounds half up.
  - Saturate `r` to [−32768, 32767] and register it into `mix_out`.
  - Pulse `mix_valid`, then go to IDLE.
- **Busy and overrun:**
  - `busy` = state ≠ IDLE.
  - A `sample_tick` while busy is ignored: the snapshot is not disturbed and no restart occurs. That tick sets `overrun`.
  - `clear_overrun` clears `overrun`. If a set and a clear happen in the same cycle, set wins.
- **Snapshot semantics:** inputs may change freely after the capture cycle. Only snapshot values are used.

## Timing
- **Reset (asynchronous assertion):**
  - State goes to IDLE. `mix_out`, `mix_valid`, `busy`, `overrun`, accumulator, index and snapshots all go to 0.
  - Reset asserted mid-MAC aborts the mix. No `mix_valid` is produced, and `mix_out` reads 0.
- **Release:** synchronous to `clk`. The first tick is honoured on the first edge after release.
- **Latency:** with the tick sampled at edge 0:
  - MAC accumulates on edges 1..15.
  - DONE registers the output at edge 16, so `mix_valid` is high for exactly one cycle after edge 16.
  - `busy` is high from after edge 0 through edge 16 (16 cycles).
  - A tick sampled at edge 16 is still an overrun. A tick at edge 17 or later starts a new mix.
- **Throughput:** one mix per 17 clocks at minimum, far below the 44.1 kHz tick period.
- **Back-to-back ticks:** the spacing between ticks only matters against the 17-cycle window above.

## Test plan
- **Single band, `OUT_SHIFT`=4:** band0 = 16384, env0 = 65535, all valid, all enabled, other envelopes 0.
  - Expect `mix_out` = 1024 and `mix_valid` for 1 cycle, 16 cycles after the tick.
- **Valid and mask gating:** same stimulus as above, but with valid_bus[0] = 0, and separately with band_enable[0] = 0.
  - Expect `mix_out` = 0 in both runs.
- **Full scale, `OUT_SHIFT`=4:** all bands = −32768, all env = 65535.
  - Expect `mix_out` = −30720. No overflow.
- **Saturation, `OUT_SHIFT`=0:** all bands = 32767, env = 65535. Expect `mix_out` = 32767.
  - Repeat with all bands = −32768. Expect −32768.
- **Overrun:** issue a second tick 5 cycles after the first.
  - Expect the first result to be unchanged and `overrun` = 1 and held.
  - Assert `clear_overrun` together with a new busy-time tick and expect `overrun` to stay 1.
  - Assert `clear_overrun` alone and expect 0.
- **Reset mid-operation:** assert `rst` 8 cycles after a tick.
  - Expect all outputs 0 immediately and no `mix_valid`.
  - After release, the next tick produces a correct result.
